// File: rtl/tdc_pkg.sv
// Shared TDC definitions: default widths, result word layout and FSM encoding.
package tdc_pkg;

    localparam int FINE_W_DEF   = 5;
    localparam int COARSE_W_DEF = 4;

    // Result word is {timeout, underflow, interval}
    localparam int RES_W_DEF = 2 + COARSE_W_DEF + FINE_W_DEF;

    function automatic int res_width(input int fine_w, input int coarse_w);
        return 2 + coarse_w + fine_w;
    endfunction

    function automatic int timeout_bit(input int res_w);
        return res_w - 1;
    endfunction

    function automatic int underflow_bit(input int res_w);
        return res_w - 2;
    endfunction

    localparam int TIMEOUT_BIT   = timeout_bit(RES_W_DEF);
    localparam int UNDERFLOW_BIT = underflow_bit(RES_W_DEF);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_STOP = 2'd1;
    localparam logic [1:0] ST_COMPUTE   = 2'd2;
    localparam logic [1:0] ST_PUSH      = 2'd3;

endpackage

// File: rtl/tdc_readout_if.sv
// Measurement input and result stream between TDC front end, readout and serialiser.
interface tdc_readout_if #(
    parameter int FINE_W   = tdc_pkg::FINE_W_DEF,
    parameter int COARSE_W = tdc_pkg::COARSE_W_DEF
);
    localparam int RES_W = tdc_pkg::res_width(FINE_W, COARSE_W);

    logic                start_valid;
    logic [FINE_W-1:0]   start_bin;
    logic                stop_valid;
    logic [FINE_W-1:0]   stop_bin;
    logic [COARSE_W-1:0] coarse_count;
    logic                out_valid;
    logic                out_ready;
    logic [RES_W-1:0]    out_data;

    // Producer of measurements / consumer of results
    modport master (
        output start_valid, start_bin, stop_valid, stop_bin, coarse_count, out_ready,
        input  out_valid, out_data
    );

    // The readout block
    modport slave (
        input  start_valid, start_bin, stop_valid, stop_bin, coarse_count, out_ready,
        output out_valid, out_data
    );

endinterface

// File: rtl/tdc_sync_fifo.sv
// Single-clock FIFO with registered head word; the head appears one cycle after
// the push that fills an empty FIFO. A pop frees a slot for a same-cycle push.
module tdc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [PTR_W:0]   count, count_n;
    logic             pop_eff, push_eff;
    logic [WIDTH-1:0] head_n;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign rd_ptr_n = pop_eff ? rd_ptr + 1'b1 : rd_ptr;

    // Next occupancy and next head word, so rd_data can be a plain register
    always_comb begin
        count_n = count;
        case ({push_eff, pop_eff})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
        head_n = '0;
        if (count_n != '0) begin
            if (empty || (count == (PTR_W+1)'(1) && pop_eff))
                head_n = push_data;
            else
                head_n = mem[rd_ptr_n];
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_eff)
            mem[wr_ptr] <= push_data;
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push_eff)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            rd_data <= head_n;
        end
    end

endmodule

// File: rtl/tdc_readout.sv
// TDC readout: captures start/stop fine bins and coarse count, computes the
// interval in fine-bin units with underflow/timeout flags, and queues results.
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int FINE_W      = FINE_W_DEF,
    parameter int COARSE_W    = COARSE_W_DEF,
    parameter int TIMEOUT_CYC = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int DROP_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    tdc_readout_if.slave      bus,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);
    localparam int IV_W   = COARSE_W + FINE_W;
    localparam int RAW_W  = IV_W + 1;
    localparam int RES_W  = res_width(FINE_W, COARSE_W);
    localparam int TO_BIT = timeout_bit(RES_W);
    localparam int UF_BIT = underflow_bit(RES_W);
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [1:0]          state;
    logic [FINE_W-1:0]   start_q, stop_q;
    logic [COARSE_W-1:0] coarse_q;
    logic                tmo_q;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [RES_W-1:0]    result, result_c;
    logic [RAW_W-1:0]    raw;

    logic                fifo_full, fifo_empty, pop, push, push_ok;
    logic [1:0]          drop_inc;
    logic [DROP_W:0]     drop_sum;

    assign busy = (state != ST_IDLE);

    // Signed difference with one spare bit; the MSB marks stop-before-start
    assign raw = {1'b0, coarse_q, {FINE_W{1'b0}}} + RAW_W'(start_q) - RAW_W'(stop_q);

    // Result word selection; timeout overrides any captured arithmetic
    always_comb begin
        result_c = '0;
        if (tmo_q)
            result_c = {1'b1, 1'b0, {IV_W{1'b1}}};
        else if (raw[RAW_W-1])
            result_c[UF_BIT] = 1'b1;
        else
            result_c[IV_W-1:0] = raw[IV_W-1:0];
    end

    // Measurement FSM: first start wins, stop beats a same-cycle timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            start_q  <= '0;
            stop_q   <= '0;
            coarse_q <= '0;
            tmo_q    <= 1'b0;
            tmo_cnt  <= '0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        start_q <= bus.start_bin;
                        tmo_cnt <= '0;
                        tmo_q   <= 1'b0;
                        state   <= ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus.stop_valid) begin
                        stop_q   <= bus.stop_bin;
                        coarse_q <= bus.coarse_count;
                        state    <= ST_COMPUTE;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        tmo_q <= 1'b1;
                        state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    result <= result_c;
                    state  <= ST_PUSH;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop     = bus.out_valid && bus.out_ready;
    assign push    = (state == ST_PUSH);
    assign push_ok = !fifo_full || pop;

    tdc_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (result),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rd_data   (bus.out_data)
    );

    assign bus.out_valid = !fifo_empty;

    // A busy-time start and a full-FIFO push can coincide, so up to two drops per cycle
    assign drop_inc = {1'b0, bus.start_valid && (state == ST_COMPUTE || state == ST_PUSH)}
                    + {1'b0, push && !push_ok};
    assign drop_sum = {1'b0, drop_count} + (DROP_W+1)'(drop_inc);

    // Saturating lost-event counter
    always_ff @(posedge clk) begin
        if (rst)
            drop_count <= '0;
        else if (drop_inc != 2'd0)
            drop_count <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end

endmodule

// File: doc/tdc_readout.md
Name: tdc_readout

Overview:
- Consumer end of the TDC measurement interface. Captures the start fine bin, the stop fine bin and the coarse clock count produced by the TDC front end.
- Computes the hit-to-hit interval in fine-bin units, flags underflow and timeout conditions, and buffers the results in a FIFO.
- Presents results on a valid/ready stream toward the readout/serialiser.
- Sits directly downstream of the TDC core, in the same clock domain.

Parameters:
- FINE_W, 5, width of start/stop fine bins; taps per clock period = 2**FINE_W.
- COARSE_W, 4, width of coarse clock count.
- TIMEOUT_CYC, 16, cycles in WAIT_STOP before a timeout event is emitted; must be >= 2.
- FIFO_DEPTH, 4, result FIFO entries; power of two.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  one-cycle pulse: start_bin valid
- start_bin  in  FINE_W  start fine bin (thermometer-decoded)
- stop_valid  in  1  one-cycle pulse: stop_bin and coarse_count valid
- stop_bin  in  FINE_W  stop fine bin
- coarse_count  in  COARSE_W  clock edges between start and stop
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  2+COARSE_W+FINE_W  {timeout, underflow, interval}
- drop_count  out  DROP_W  events lost (busy or FIFO full), saturating
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM goes to IDLE; FIFO is emptied; out_valid=0, out_data=0, drop_count=0, busy=0; timeout counter cleared. Reset mid-event discards the event without counting it.
- FSM states: IDLE, WAIT_STOP, COMPUTE, PUSH.
- IDLE:
  - start_valid: latch start_bin, clear the timeout counter, go to WAIT_STOP.
  - stop_valid alone is ignored (orphan stop, not counted).
  - start_valid and stop_valid in the same cycle: start taken, stop ignored.
- WAIT_STOP:
  - Counter increments each cycle.
  - stop_valid: latch stop_bin and coarse_count, go to COMPUTE.
  - Counter == TIMEOUT_CYC-1 with no stop: set the timeout flag, go to COMPUTE.
  - stop_valid in the same cycle as the timeout: stop wins, no timeout flag.
  - start_valid in WAIT_STOP is ignored (first-start semantics), not counted.
- COMPUTE (1 cycle), registered arithmetic at width COARSE_W+FINE_W+1:
  - raw = coarse_count*2**FINE_W + start_bin - stop_bin.
  - raw < 0: interval=0, underflow=1.
  - Otherwise interval = raw[COARSE_W+FINE_W-1:0]; raw never exceeds 2**(COARSE_W+FINE_W)-1.
  - Timeout: interval = all ones, underflow=0.
- PUSH (1 cycle):
  - FIFO not full: write {timeout, underflow, interval}.
  - FIFO full: discard the word and increment drop_count.
  - Then go to IDLE.
- Busy drops: start_valid received during COMPUTE or PUSH increments drop_count.
- drop_count saturates at all ones.
- Latency:
  - Stop sampled at edge N; COMPUTE in N+1, PUSH in N+2; the word is visible with out_valid=1 at N+3 if the FIFO was empty.
  - A new start is accepted from N+3 (IDLE).
- FIFO:
  - Registered output, first-word-fall-through after one cycle.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop allowed when full: the pop frees the slot, so the push succeeds.
  - out_data is held stable while out_valid && !out_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data equals the head entry when out_valid=1, else 0.
- busy=1 in WAIT_STOP, COMPUTE and PUSH.

Decomposition:
- Shared package tdc_pkg:
  - FINE_W and COARSE_W defaults.
  - Flag bit positions: TIMEOUT_BIT = MSB, UNDERFLOW_BIT = MSB-1.
  - Result word width.
  - FSM state encoding constants.
- Sub-module tdc_sync_fifo (parameters WIDTH, DEPTH): single clock, synchronous active-high rst, full/empty flags, registered read data. Reusable by later TDC channels.

Test Plan:
- Normal measurement: start_bin=20, then stop_bin=7, coarse_count=3 -> out_data={0,0,109} at stop+3 cycles; busy drops at stop+3.
- Underflow: start_bin=4, stop_bin=10, coarse_count=0 -> {0,1,0}.
- Timeout: start, no stop -> after 16 WAIT_STOP cycles out_data={1,0,511}. Separately, stop on the timeout cycle with coarse=2, bins 0/0 -> {0,0,64}.
- Backpressure: out_ready=0, five complete events (FIFO_DEPTH=4) -> 4 words stored, drop_count=1. Then out_ready=1 -> the 4 words drain in order, one per cycle.
- Busy and ordering: start pulse during COMPUTE -> drop_count+1. Start and stop in the same IDLE cycle -> stop ignored; FSM remains in WAIT_STOP.
- Reset mid-operation: rst asserted in WAIT_STOP with 2 words queued -> next cycle out_valid=0, busy=0, drop_count=0; subsequent event 1/0/coarse 1 -> {0,0,33}.
